dc_fu_axi_read_responder: RTL and testbench



---
 rtl/dc_fu_axi_read_responder_if.sv | 27 ++
 rtl/dc_fu_axi_read_responder.sv | 185 ++++++++++++++++++
 tb/tb_dc_fu_axi_read_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dc_fu_axi_read_responder_if.sv
// AXI4 read-channel (AR + R) bundle between the fetching-unit DMA and the read responder.
interface dc_fu_axi_read_responder_if #(
  parameter int unsigned AXI_ARADDR_WIDTH = 32,
  parameter int unsigned READ_DATA_SIZE   = 1
);
  localparam int unsigned DATA_W = 8 * (2 ** READ_DATA_SIZE);

  logic                        axi_arvalid;
  logic                        axi_arready;
  logic [AXI_ARADDR_WIDTH-1:0] axi_araddr;
  logic [7:0]                  axi_arlen;
  logic                        axi_rvalid;
  logic                        axi_rready;
  logic [DATA_W-1:0]           axi_rdata;
  logic [1:0]                  axi_rresp;
  logic                        axi_rlast;

  modport master (
    output axi_arvalid, axi_araddr, axi_arlen, axi_rready,
    input  axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast
  );

  modport slave (
    input  axi_arvalid, axi_araddr, axi_arlen, axi_rready,
    output axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast
  );
endinterface

// File: rtl/dc_fu_axi_read_responder.sv
// AXI4 read responder: queues incrementing bursts and streams R beats from a
// synchronous-read local memory, flagging beats beyond the memory span as SLVERR.
module dc_fu_axi_read_responder #(
  parameter int unsigned AXI_ARADDR_WIDTH = 32,
  parameter int unsigned READ_DATA_SIZE   = 1,
  parameter int unsigned MEM_ADDR_WIDTH   = 12,
  parameter int unsigned AR_QUEUE_DEPTH   = 2
) (
  input  logic                                clk,
  input  logic                                nrst,
  dc_fu_axi_read_responder_if.slave           axi,
  output logic                                mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0]           mem_rd_addr,
  input  logic [8*(2**READ_DATA_SIZE)-1:0]    mem_rd_data
);
  localparam int unsigned DATA_W     = 8 * (2 ** READ_DATA_SIZE);
  localparam int unsigned BEAT_BYTES = 2 ** READ_DATA_SIZE;
  localparam int unsigned TOP_BIT    = MEM_ADDR_WIDTH + READ_DATA_SIZE;
  localparam int unsigned QPTR_W     = $clog2(AR_QUEUE_DEPTH);
  localparam int unsigned QCNT_W     = $clog2(AR_QUEUE_DEPTH + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  // AR queue
  logic [AXI_ARADDR_WIDTH-1:0] q_addr [AR_QUEUE_DEPTH];
  logic [7:0]                  q_len  [AR_QUEUE_DEPTH];
  logic [QPTR_W-1:0]           q_wr_ptr, q_rd_ptr;
  logic [QCNT_W-1:0]           q_cnt;
  logic                        q_push, q_pop, q_empty;
  logic [AXI_ARADDR_WIDTH-1:0] head_addr;
  logic [7:0]                  head_len;

  // burst engine
  state_t                      state_q, state_d;
  logic [AXI_ARADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                  rem_q, rem_d;
  logic                        issue, issue_ok, beat_last, beat_ok;
  logic [AXI_ARADDR_WIDTH-1:0] beat_addr;

  // in-flight stage and R output buffer
  logic              infl_valid, infl_err, infl_last;
  logic [DATA_W-1:0] buf_data [2];
  logic              buf_err  [2];
  logic              buf_last [2];
  logic              buf_wr_ptr, buf_rd_ptr;
  logic [1:0]        buf_cnt;
  logic [1:0]        pending;
  logic              r_pop;

  assign q_empty          = (q_cnt == '0);
  assign axi.axi_arready  = nrst && (q_cnt != QCNT_W'(AR_QUEUE_DEPTH));
  assign q_push           = axi.axi_arvalid && axi.axi_arready;
  assign head_addr        = q_addr[q_rd_ptr];
  assign head_len         = q_len[q_rd_ptr];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      q_wr_ptr <= '0;
      q_rd_ptr <= '0;
      q_cnt    <= '0;
    end else begin
      if (q_push) q_wr_ptr <= q_wr_ptr + QPTR_W'(1);
      if (q_pop)  q_rd_ptr <= q_rd_ptr + QPTR_W'(1);
      case ({q_push, q_pop})
        2'b10:   q_cnt <= q_cnt + QCNT_W'(1);
        2'b01:   q_cnt <= q_cnt - QCNT_W'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // Queue payload needs no reset; the count guards every read.
  always_ff @(posedge clk) begin
    if (q_push) begin
      q_addr[q_wr_ptr] <= axi.axi_araddr & ~AXI_ARADDR_WIDTH'(BEAT_BYTES - 1);
      q_len[q_wr_ptr]  <= axi.axi_arlen;
    end
  end

  // Occupancy counts buffered plus in-flight beats; a same-cycle R pop frees a slot.
  assign r_pop    = axi.axi_rvalid && axi.axi_rready;
  assign pending  = buf_cnt + 2'(infl_valid);
  assign issue_ok = nrst && ((pending < 2'd2) || ((pending == 2'd2) && r_pop));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // addr_q/rem_q hold the next beat to issue and the beats left after it.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    issue     = 1'b0;
    q_pop     = 1'b0;
    beat_addr = addr_q;
    beat_last = (rem_q == 8'd0);
    case (state_q)
      S_IDLE: begin
        if (!q_empty && issue_ok) begin
          q_pop     = 1'b1;
          issue     = 1'b1;
          beat_addr = head_addr;
          beat_last = (head_len == 8'd0);
          addr_d    = head_addr + AXI_ARADDR_WIDTH'(BEAT_BYTES);
          rem_d     = head_len - 8'd1;
          if (head_len != 8'd0) state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (issue_ok) begin
          issue = 1'b1;
          if (rem_q != 8'd0) begin
            addr_d = addr_q + AXI_ARADDR_WIDTH'(BEAT_BYTES);
            rem_d  = rem_q - 8'd1;
          end else if (!q_empty) begin
            q_pop  = 1'b1;
            addr_d = head_addr;
            rem_d  = head_len;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign beat_ok     = ((beat_addr >> TOP_BIT) == '0);
  assign mem_rd_en   = issue && beat_ok;
  assign mem_rd_addr = beat_addr[TOP_BIT-1:READ_DATA_SIZE];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      infl_valid <= 1'b0;
      infl_err   <= 1'b0;
      infl_last  <= 1'b0;
    end else begin
      infl_valid <= issue;
      infl_err   <= issue && !beat_ok;
      infl_last  <= issue && beat_last;
    end
  end

  // Two-entry R buffer; the in-flight beat lands here as memory data arrives.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_err[i]  <= 1'b0;
        buf_last[i] <= 1'b0;
      end
      buf_wr_ptr <= 1'b0;
      buf_rd_ptr <= 1'b0;
      buf_cnt    <= 2'd0;
    end else begin
      if (infl_valid) begin
        buf_data[buf_wr_ptr] <= infl_err ? '0 : mem_rd_data;
        buf_err[buf_wr_ptr]  <= infl_err;
        buf_last[buf_wr_ptr] <= infl_last;
        buf_wr_ptr           <= ~buf_wr_ptr;
      end
      if (r_pop) buf_rd_ptr <= ~buf_rd_ptr;
      case ({infl_valid, r_pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  assign axi.axi_rvalid = (buf_cnt != 2'd0);
  assign axi.axi_rdata  = buf_data[buf_rd_ptr];
  assign axi.axi_rresp  = buf_err[buf_rd_ptr] ? 2'b10 : 2'b00;
  assign axi.axi_rlast  = buf_last[buf_rd_ptr];

endmodule

// File: tb/tb_dc_fu_axi_read_responder.sv
// Self-checking bench for dc_fu_axi_read_responder: table of bursts plus
// hand-written corner sequences, all R beats checked against a scoreboard.
module tb_dc_fu_axi_read_responder;
  logic        clk = 1'b0;
  logic        nrst;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [15:0] mem_rd_data;

  always #5 clk = ~clk;

  dc_fu_axi_read_responder_if #(.AXI_ARADDR_WIDTH(32), .READ_DATA_SIZE(1)) axi ();

  dc_fu_axi_read_responder #(
    .AXI_ARADDR_WIDTH(32), .READ_DATA_SIZE(1), .MEM_ADDR_WIDTH(12), .AR_QUEUE_DEPTH(2)
  ) dut (
    .clk(clk), .nrst(nrst), .axi(axi),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  // memory word[k] = k, one-cycle synchronous read
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= 16'(mem_rd_addr);

  typedef struct {
    logic [15:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [15:0] first_data;
    logic [1:0]  first_resp;
    logic [1:0]  last_resp;
  } vec_t;

  beat_t sb[$];
  beat_t obs[$];
  int    errors = 0;
  int    checks = 0;
  int    iss_cnt = 0, acc_cnt = 0, max_ahead = 0;
  logic  stall_prev = 1'b0;
  beat_t prev;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_expected(input logic [31:0] a, input logic [7:0] l);
    logic [31:0] ba;
    beat_t b;
    for (int i = 0; i <= int'(l); i++) begin
      ba     = (a & ~32'd1) + 32'(2 * i);
      b.data = (ba < 32'h2000) ? 16'(ba >> 1) : 16'h0;
      b.resp = (ba < 32'h2000) ? 2'b00 : 2'b10;
      b.last = (i == int'(l));
      sb.push_back(b);
    end
  endtask

  // R monitor: scoreboard compare, stall stability, issue-ahead tracking
  always @(negedge clk) begin
    beat_t e, g;
    if (nrst) begin
      g.data = axi.axi_rdata; g.resp = axi.axi_rresp; g.last = axi.axi_rlast;
      if (stall_prev)
        chk("r_stable", {axi.axi_rvalid, g.data, g.resp, g.last},
            {1'b1, prev.data, prev.resp, prev.last});
      if (mem_rd_en) iss_cnt++;
      if (axi.axi_rvalid && axi.axi_rready) begin
        acc_cnt++;
        obs.push_back(g);
        if (sb.size() == 0) begin
          chk("unexpected_beat", {g.data, g.resp, g.last}, 32'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("beat", {13'd0, g.data, g.resp, g.last}, {13'd0, e.data, e.resp, e.last});
        end
      end
      if (iss_cnt - acc_cnt > max_ahead) max_ahead = iss_cnt - acc_cnt;
      stall_prev = axi.axi_rvalid && !axi.axi_rready;
      prev = g;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send_ar(input logic [31:0] a, input logic [7:0] l);
    int n = 0;
    axi.axi_arvalid = 1'b1;
    axi.axi_araddr  = a;
    axi.axi_arlen   = l;
    do begin @(negedge clk); n++; end while (!axi.axi_arready && n < 200);
    chk("ar_accept", 32'(axi.axi_arready), 32'd1);
    if (axi.axi_arready) push_expected(a, l);
    @(posedge clk); #1;
    axi.axi_arvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin @(posedge clk); n++; end
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // call right after send_ar returns; checks the 3-cycle AR-to-R latency
  task automatic check_latency(input string name);
    int lat = 0;
    do begin
      @(negedge clk); lat++;
      if (lat == 1) chk({name, "_mem_rd_en"}, 32'(mem_rd_en), 32'd1);
    end while (!axi.axi_rvalid && lat < 20);
    chk({name, "_latency"}, 32'(lat), 32'd3);
  endtask

  vec_t vecs[8];

  initial begin
    int run, n;

    vecs[0] = '{32'h0000_0100, 8'd3, 16'h0080, 2'b00, 2'b00};
    vecs[1] = '{32'h0000_0101, 8'd0, 16'h0080, 2'b00, 2'b00};
    vecs[2] = '{32'h0000_1FFC, 8'd3, 16'h0FFE, 2'b00, 2'b10};
    vecs[3] = '{32'h0000_0000, 8'd0, 16'h0000, 2'b00, 2'b00};
    vecs[4] = '{32'h0000_1FFE, 8'd1, 16'h0FFF, 2'b00, 2'b10};
    vecs[5] = '{32'hFFFF_FFFE, 8'd1, 16'h0000, 2'b10, 2'b00};
    vecs[6] = '{32'h0000_2000, 8'd0, 16'h0000, 2'b10, 2'b10};
    vecs[7] = '{32'h0000_0FFF, 8'd2, 16'h07FF, 2'b00, 2'b00};

    nrst = 1'b0;
    axi.axi_arvalid = 1'b0;
    axi.axi_araddr  = '0;
    axi.axi_arlen   = '0;
    axi.axi_rready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 32'(axi.axi_arready), 32'd0);
    chk("rst_rvalid", 32'(axi.axi_rvalid), 32'd0);
    chk("rst_rlast", 32'(axi.axi_rlast), 32'd0);
    chk("rst_rdata", 32'(axi.axi_rdata), 32'd0);
    chk("rst_rresp", 32'(axi.axi_rresp), 32'd0);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("post_rst_arready", 32'(axi.axi_arready), 32'd1);
    @(posedge clk); #1;

    // first scenario with latency
    axi.axi_rready = 1'b1;
    obs.delete();
    send_ar(32'h100, 8'd3);
    check_latency("basic");
    wait_drain();
    chk("basic_nbeats", 32'(obs.size()), 32'd4);

    // table of bursts
    foreach (vecs[i]) begin
      obs.delete();
      send_ar(vecs[i].addr, vecs[i].len);
      wait_drain();
      chk($sformatf("vec%0d_nbeats", i), 32'(obs.size()), 32'(vecs[i].len) + 32'd1);
      if (obs.size() != 0) begin
        chk($sformatf("vec%0d_first_data", i), 32'(obs[0].data), 32'(vecs[i].first_data));
        chk($sformatf("vec%0d_first_resp", i), 32'(obs[0].resp), 32'(vecs[i].first_resp));
        chk($sformatf("vec%0d_last_resp", i), 32'(obs[obs.size()-1].resp), 32'(vecs[i].last_resp));
        chk($sformatf("vec%0d_rlast", i), 32'(obs[obs.size()-1].last), 32'd1);
      end
    end

    // back-to-back bursts, no bubble
    obs.delete();
    send_ar(32'h0, 8'd15);
    send_ar(32'h20, 8'd15);
    n = 0;
    while (!axi.axi_rvalid && n < 20) begin @(negedge clk); n++; end
    run = 0;
    while (axi.axi_rvalid && run < 40) begin run++; @(negedge clk); end
    chk("b2b_run", 32'(run), 32'd32);
    wait_drain();
    chk("b2b_nbeats", 32'(obs.size()), 32'd32);
    if (obs.size() == 32) begin
      chk("b2b_last16", 32'(obs[15].last), 32'd1);
      chk("b2b_last15", 32'(obs[14].last), 32'd0);
      chk("b2b_last32", 32'(obs[31].last), 32'd1);
    end

    // random rready over one burst
    obs.delete();
    iss_cnt = 0; acc_cnt = 0; max_ahead = 0;
    axi.axi_rready = 1'b0;
    send_ar(32'h40, 8'd15);
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(posedge clk); #1;
      axi.axi_rready = 1'($urandom_range(0, 1));
      n++;
    end
    axi.axi_rready = 1'b1;
    wait_drain();
    chk("rand_nbeats", 32'(obs.size()), 32'd16);
    chk("rand_ahead_le2", 32'(max_ahead <= 2), 32'd1);

    // queue full with rready low
    axi.axi_rready = 1'b0;
    obs.delete();
    send_ar(32'h200, 8'd3);
    send_ar(32'h300, 8'd3);
    send_ar(32'h400, 8'd3);
    axi.axi_arvalid = 1'b1;
    axi.axi_araddr  = 32'h500;
    axi.axi_arlen   = 8'd3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("full_arready%0d", k), 32'(axi.axi_arready), 32'd0);
    end
    @(posedge clk); #1;
    axi.axi_rready = 1'b1;
    send_ar(32'h500, 8'd3);
    wait_drain();
    chk("full_nbeats", 32'(obs.size()), 32'd16);

    // reset during beat 5 of a 16-beat burst
    send_ar(32'h0, 8'd15);
    repeat (6) @(posedge clk);
    #1;
    nrst = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_rvalid", 32'(axi.axi_rvalid), 32'd0);
    chk("mid_rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("mid_rst_rlast", 32'(axi.axi_rlast), 32'd0);
    chk("mid_rst_arready", 32'(axi.axi_arready), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("mid_rst_arready_back", 32'(axi.axi_arready), 32'd1);
    repeat (3) @(posedge clk);
    chk("mid_rst_quiet", 32'(axi.axi_rvalid), 32'd0);
    #1;
    obs.delete();
    send_ar(32'h100, 8'd3);
    check_latency("after_rst");
    wait_drain();
    chk("after_rst_nbeats", 32'(obs.size()), 32'd4);
    if (obs.size() == 4) begin
      chk("after_rst_d0", 32'(obs[0].data), 32'h80);
      chk("after_rst_d3", 32'(obs[3].data), 32'h83);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
